// File: rtl/ifetch_seq32.sv
// Multi-cycle instruction fetch unit: owns the PC, fetches over a req/ack handshake,
// holds the word for the decoder and commits the next PC (branch/jump/jal/jr) on advance.
module ifetch_seq32 #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        advance,
  input  logic        Branch,
  input  logic        nBranch,
  input  logic        Jmp,
  input  logic        Jal,
  input  logic        Jrn,
  input  logic        Zero,
  input  logic [31:0] Read_data_1,
  output logic [31:0] Instruction,
  output logic [5:0]  Opcode,
  output logic [5:0]  Function_opcode,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4,
  output logic [31:0] link_addr
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   link_q, link_d;
  logic [XLEN-1:0]   pc_plus_4;
  logic [XLEN-1:0]   br_off;
  logic [XLEN-1:0]   next_pc;
  logic              br_taken;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= PC_RESET;
      instr_q <= '0;
      valid_q <= 1'b0;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      link_q  <= link_d;
    end
  end

  // Next-PC selection: jr beats j/jal beats a taken branch beats sequential.
  always_comb begin
    pc_plus_4 = pc_q + XLEN'(4);
    br_off    = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    br_taken  = (Branch & Zero) | (nBranch & ~Zero);
    if (Jrn) begin
      next_pc = Read_data_1 & ~XLEN'(3);
    end else if (Jmp | Jal) begin
      next_pc = {pc_plus_4[31:28], instr_q[25:0], 2'b00};
    end else if (br_taken) begin
      next_pc = pc_plus_4 + br_off;
    end else begin
      next_pc = pc_plus_4;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    link_d  = link_q;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (advance) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = ST_FETCH;
          if (Jal) link_d = pc_plus_4;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign imem_req        = (state_q == ST_FETCH);
  assign imem_addr       = pc_q;
  assign Instruction     = instr_q;
  assign Opcode          = instr_q[31:26];
  assign Function_opcode = instr_q[5:0];
  assign instr_valid     = valid_q;
  assign PC              = pc_q;
  assign PC_plus_4       = pc_plus_4;
  assign link_addr       = link_q;

endmodule
